response_fault_injector: RTL and testbench



---
 rtl/response_fault_injector.sv | 192 +++++++++++++++++++
 tb/tb_response_fault_injector.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/response_fault_injector.sv
// response_fault_injector
// Programmable fault injector on the PSL response path. It sits between the
// latched PSL response and afu_control. It counts valid responses and, when a
// programmed rule matches a response's ordinal, replaces the response code.
// It is a one-cycle registered stage with no backpressure.
//
// Build option: RESPONSE_FAULT_INJECT_EN
//   defined   - rule table, ordinal counter and comparators are present
//   undefined - the block is a plain one-cycle register of response_in.
//               inject_count and response_ordinal are tied to 0.
//
// Ports
//   clock            AFU clock
//   reset            synchronous, active-high reset
//   enabled_in       job running; responses are counted and rewritten only while high
//   response_in      latched PSL response
//   cfg_valid        single-cycle rule write strobe
//   cfg_index        rule to write (out-of-range writes are ignored)
//   cfg_enable       rule active
//   cfg_mode         0 = ONESHOT, 1 = WINDOW
//   cfg_start        first ordinal
//   cfg_end          last ordinal (WINDOW only)
//   cfg_code         replacement response code
//   cfg_clear        zeroes the ordinal counter and inject_count
//   response_out     response to afu_control, one cycle after response_in
//   inject_count     saturating count of rewritten responses
//   response_ordinal current ordinal counter value

package response_fault_injector_pkg;

   // Latched PSL response bundle
   typedef struct packed {
      logic        valid;
      logic [7:0]  tag;
      logic        tag_parity;
      logic [7:0]  response;
      logic        response_parity;
      logic [8:0]  credits;
      logic [1:0]  cache_state;
      logic [12:0] cache_pos;
   } ResponseInterface;

   localparam logic [7:0] RESP_DONE    = 8'h00;
   localparam logic [7:0] RESP_AERROR  = 8'h01;
   localparam logic [7:0] RESP_DERROR  = 8'h03;
   localparam logic [7:0] RESP_FLUSHED = 8'h06;
   localparam logic [7:0] RESP_FAULT   = 8'h07;
   localparam logic [7:0] RESP_PAGED   = 8'h0A;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_WINDOW  = 1'b1;

   // PSL parity is odd: the parity bit makes the total number of ones odd
   function automatic logic odd_parity(input logic [7:0] value);
      return ~(^value);
   endfunction

endpackage

module response_fault_injector
   import response_fault_injector_pkg::*;
#(
   parameter int unsigned NUM_RULES   = 4,
   parameter int unsigned COUNT_WIDTH = 16,
   localparam int unsigned IDX_W      = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   enabled_in,
   input  ResponseInterface       response_in,
   input  logic                   cfg_valid,
   input  logic [IDX_W-1:0]       cfg_index,
   input  logic                   cfg_enable,
   input  logic                   cfg_mode,
   input  logic [COUNT_WIDTH-1:0] cfg_start,
   input  logic [COUNT_WIDTH-1:0] cfg_end,
   input  logic [7:0]             cfg_code,
   input  logic                   cfg_clear,
   output ResponseInterface       response_out,
   output logic [31:0]            inject_count,
   output logic [COUNT_WIDTH-1:0] response_ordinal
);

`ifdef RESPONSE_FAULT_INJECT_EN

   localparam logic [COUNT_WIDTH-1:0] ORD_MAX = '1;
   localparam logic [31:0]            CNT_MAX = '1;

   logic [NUM_RULES-1:0]   rule_enable;
   logic [NUM_RULES-1:0]   rule_mode;
   logic [COUNT_WIDTH-1:0] rule_start [NUM_RULES];
   logic [COUNT_WIDTH-1:0] rule_end   [NUM_RULES];
   logic [7:0]             rule_code  [NUM_RULES];

   logic [COUNT_WIDTH-1:0] ord;
   logic [31:0]            inject_cnt;

   logic                   count_c;
   logic                   cfg_write_c;
   logic                   hit_c;
   logic [7:0]             hit_code_c;

   assign count_c     = response_in.valid && enabled_in;
   assign cfg_write_c = cfg_valid && (32'(cfg_index) < 32'(NUM_RULES));

   // Lowest-index matching rule wins; WINDOW rules never touch PAGED so a resume stays clean
   always_comb begin
      hit_c      = 1'b0;
      hit_code_c = 8'h00;
      for (int i = 0; i < int'(NUM_RULES); i++) begin
         if (!hit_c && count_c && rule_enable[i]) begin
            if (rule_mode[i] == MODE_WINDOW) begin
               if ((ord >= rule_start[i]) && (ord <= rule_end[i]) &&
                   (response_in.response != RESP_PAGED)) begin
                  hit_c      = 1'b1;
                  hit_code_c = rule_code[i];
               end
            end else if (ord == rule_start[i]) begin
               hit_c      = 1'b1;
               hit_code_c = rule_code[i];
            end
         end
      end
   end

   // Output stage, rule table and counters; rule writes take effect from the next response
   always_ff @(posedge clock) begin
      if (reset) begin
         response_out <= '0;
         ord          <= '0;
         inject_cnt   <= '0;
         rule_enable  <= '0;
         rule_mode    <= '0;
         for (int i = 0; i < int'(NUM_RULES); i++) begin
            rule_start[i] <= '0;
            rule_end[i]   <= '0;
            rule_code[i]  <= '0;
         end
      end else begin
         response_out <= response_in;
         if (hit_c) begin
            response_out.response        <= hit_code_c;
            response_out.response_parity <= odd_parity(hit_code_c);
         end

         if (cfg_write_c) begin
            rule_enable[cfg_index] <= cfg_enable;
            rule_mode[cfg_index]   <= cfg_mode;
            rule_start[cfg_index]  <= cfg_start;
            rule_end[cfg_index]    <= cfg_end;
            rule_code[cfg_index]   <= cfg_code;
         end

         // Clear wins over increment; both counters saturate
         if (cfg_clear) begin
            ord        <= '0;
            inject_cnt <= '0;
         end else begin
            if (count_c && (ord != ORD_MAX)) begin
               ord <= ord + COUNT_WIDTH'(1);
            end
            if (hit_c && (inject_cnt != CNT_MAX)) begin
               inject_cnt <= inject_cnt + 32'd1;
            end
         end
      end
   end

   assign inject_count     = inject_cnt;
   assign response_ordinal = ord;

`else

   logic unused_cfg;

   // Plain one-cycle register of the response
   always_ff @(posedge clock) begin
      if (reset) begin
         response_out <= '0;
      end else begin
         response_out <= response_in;
      end
   end

   assign inject_count     = '0;
   assign response_ordinal = '0;
   assign unused_cfg       = ^{enabled_in, cfg_valid, cfg_index, cfg_enable, cfg_mode,
                               cfg_start, cfg_end, cfg_code, cfg_clear};

`endif

endmodule

// File: tb/tb_response_fault_injector.sv
module tb_response_fault_injector;
   import response_fault_injector_pkg::*;

   logic             clock = 1'b0;
   logic             reset;
   logic             enabled_in;
   ResponseInterface response_in;
   logic             cfg_valid;
   logic [1:0]       cfg_index;
   logic             cfg_enable;
   logic             cfg_mode;
   logic [15:0]      cfg_start;
   logic [15:0]      cfg_end;
   logic [7:0]       cfg_code;
   logic             cfg_clear;

   ResponseInterface resp_out_a, resp_out_b;
   logic [31:0]      icnt_a, icnt_b;
   logic [15:0]      ord_a;
   logic [3:0]       ord_b;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state
   bit               m_en    [4];
   bit               m_mode  [4];
   int               m_start [4];
   int               m_end   [4];
   logic [7:0]       m_code  [4];
   int               m_ord     = 0;
   longint           m_cnt     = 0;
   int               m_ord_max = 65535;
   int               m_nrules  = 4;
   ResponseInterface exp_out;

   always #5 clock = ~clock;

   response_fault_injector #(.NUM_RULES(4), .COUNT_WIDTH(16)) dut_a (
      .clock(clock), .reset(reset), .enabled_in(enabled_in), .response_in(response_in),
      .cfg_valid(cfg_valid), .cfg_index(cfg_index), .cfg_enable(cfg_enable),
      .cfg_mode(cfg_mode), .cfg_start(cfg_start), .cfg_end(cfg_end), .cfg_code(cfg_code),
      .cfg_clear(cfg_clear), .response_out(resp_out_a), .inject_count(icnt_a),
      .response_ordinal(ord_a));

   response_fault_injector #(.NUM_RULES(3), .COUNT_WIDTH(4)) dut_b (
      .clock(clock), .reset(reset), .enabled_in(enabled_in), .response_in(response_in),
      .cfg_valid(cfg_valid), .cfg_index(cfg_index), .cfg_enable(cfg_enable),
      .cfg_mode(cfg_mode), .cfg_start(cfg_start[3:0]), .cfg_end(cfg_end[3:0]),
      .cfg_code(cfg_code), .cfg_clear(cfg_clear), .response_out(resp_out_b),
      .inject_count(icnt_b), .response_ordinal(ord_b));

   function automatic logic par_of(input logic [7:0] c);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(c[i]);
      return (ones % 2 == 0) ? 1'b1 : 1'b0;
   endfunction

   function automatic logic [7:0] pick_code();
      case ($urandom_range(0, 5))
         0:       return RESP_DONE;
         1:       return RESP_AERROR;
         2:       return RESP_DERROR;
         3:       return RESP_FLUSHED;
         4:       return RESP_FAULT;
         default: return RESP_PAGED;
      endcase
   endfunction

   function automatic ResponseInterface rand_resp(input logic [7:0] code, input logic v);
      ResponseInterface r;
      r.valid           = v;
      r.tag             = 8'($urandom);
      r.tag_parity      = 1'($urandom);
      r.response        = code;
      r.response_parity = par_of(code);
      r.credits         = 9'($urandom);
      r.cache_state     = 2'($urandom);
      r.cache_pos       = 13'($urandom);
      return r;
   endfunction

   task automatic idle_inputs();
      enabled_in  = 1'b1;
      response_in = '0;
      cfg_valid   = 1'b0;
      cfg_index   = '0;
      cfg_enable  = 1'b0;
      cfg_mode    = 1'b0;
      cfg_start   = '0;
      cfg_end     = '0;
      cfg_code    = '0;
      cfg_clear   = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently applied
   task automatic model_step();
      ResponseInterface e;
      int hit;
      int idx;
      if (reset) begin
         exp_out = '0;
         m_ord   = 0;
         m_cnt   = 0;
         for (int i = 0; i < 4; i++) m_en[i] = 1'b0;
         return;
      end
      e   = response_in;
      hit = -1;
      if (enabled_in && response_in.valid) begin
         for (int i = 0; i < m_nrules; i++) begin
            if (hit < 0 && m_en[i]) begin
               if (m_mode[i]) begin
                  if (m_ord >= m_start[i] && m_ord <= m_end[i] && response_in.response != RESP_PAGED)
                     hit = i;
               end else if (m_ord == m_start[i]) begin
                  hit = i;
               end
            end
         end
      end
      if (hit >= 0) begin
         e.response        = m_code[hit];
         e.response_parity = par_of(m_code[hit]);
      end
      exp_out = e;
      idx = int'(cfg_index);
      if (cfg_valid && idx < m_nrules) begin
         m_en[idx]    = cfg_enable;
         m_mode[idx]  = cfg_mode;
         m_start[idx] = int'(cfg_start) & m_ord_max;
         m_end[idx]   = int'(cfg_end) & m_ord_max;
         m_code[idx]  = cfg_code;
      end
      if (cfg_clear) begin
         m_ord = 0;
         m_cnt = 0;
      end else begin
         if (enabled_in && response_in.valid && m_ord < m_ord_max) m_ord++;
         if (hit >= 0 && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int ord_max, input int nrules);
      idle_inputs();
      m_ord_max = ord_max;
      m_nrules  = nrules;
      reset     = 1'b1;
      tick();
      reset     = 1'b0;
   endtask

   task automatic program_rule(input int idx, input bit mode, input int s, input int e,
                               input logic [7:0] code);
      response_in = '0;
      cfg_valid   = 1'b1;
      cfg_index   = 2'(idx);
      cfg_enable  = 1'b1;
      cfg_mode    = mode;
      cfg_start   = 16'(s);
      cfg_end     = 16'(e);
      cfg_code    = code;
      tick();
      cfg_valid   = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      response_in = rand_resp(RESP_FAULT, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++;
      if (resp_out_a !== '0 || icnt_a !== 32'd0 || ord_a !== 16'd0) begin
         n_fail++;
         $display("FAIL reset out=%h cnt=%0d ord=%0d required all zero", resp_out_a, icnt_a, ord_a);
      end
      n_cmp++;
      if (resp_out_b.valid !== 1'b0 || icnt_b !== 32'd0 || ord_b !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_small valid=%b cnt=%0d ord=%0d required zero", resp_out_b.valid, icnt_b, ord_b);
      end
   endtask

`ifdef RESPONSE_FAULT_INJECT_EN

   task automatic test_oneshot();
      logic [7:0] want;
      logic [7:0] sent_tag;
      do_reset(65535, 4);
      program_rule(0, 1'b0, 5, 0, RESP_PAGED);
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 2) == 0) begin
            response_in = rand_resp(pick_code(), 1'b0);
            tick();
            n_cmp++;
            if (resp_out_a !== exp_out) begin
               n_fail++;
               $display("FAIL oneshot_gap got %h want %h", resp_out_a, exp_out);
            end
         end
         response_in = rand_resp(RESP_DONE, 1'b1);
         sent_tag    = response_in.tag;
         want        = (k == 5) ? RESP_PAGED : RESP_DONE;
         tick();
         n_cmp++;
         if (resp_out_a.response !== want || resp_out_a.tag !== sent_tag || resp_out_a !== exp_out) begin
            n_fail++;
            $display("FAIL oneshot k=%0d got %h want code %h tag %h model %h", k, resp_out_a, want, sent_tag, exp_out);
         end
      end
      n_cmp++;
      if (icnt_a !== 32'd1) begin
         n_fail++;
         $display("FAIL oneshot_count got %0d want 1", icnt_a);
      end
   endtask

   task automatic test_window();
      logic [7:0] want;
      do_reset(65535, 4);
      program_rule(1, 1'b1, 30, 44, RESP_DERROR);
      for (int k = 0; k < 50; k++) begin
         response_in = rand_resp((k == 35) ? RESP_PAGED : RESP_DONE, 1'b1);
         want = (k == 35) ? RESP_PAGED : ((k >= 30 && k <= 44) ? RESP_DERROR : RESP_DONE);
         tick();
         n_cmp++;
         if (resp_out_a.response !== want || resp_out_a !== exp_out) begin
            n_fail++;
            $display("FAIL window k=%0d got %h want code %h model %h", k, resp_out_a, want, exp_out);
         end
      end
      n_cmp++;
      if (icnt_a !== 32'd14) begin
         n_fail++;
         $display("FAIL window_count got %0d want 14", icnt_a);
      end
   endtask

   task automatic test_overlap();
      logic [7:0] want;
      do_reset(65535, 4);
      program_rule(0, 1'b1, 10, 20, RESP_AERROR);
      program_rule(2, 1'b1, 15, 25, RESP_FAULT);
      for (int k = 0; k < 30; k++) begin
         response_in = rand_resp(RESP_DONE, 1'b1);
         want = (k >= 10 && k <= 20) ? RESP_AERROR : ((k >= 21 && k <= 25) ? RESP_FAULT : RESP_DONE);
         tick();
         n_cmp++;
         if (resp_out_a.response !== want || resp_out_a.response_parity !== par_of(want) ||
             resp_out_a !== exp_out) begin
            n_fail++;
            $display("FAIL overlap k=%0d got %h want code %h par %b", k, resp_out_a, want, par_of(want));
         end
      end
      n_cmp++;
      if (icnt_a !== 32'd16) begin
         n_fail++;
         $display("FAIL overlap_count got %0d want 16", icnt_a);
      end
   endtask

   task automatic test_clear();
      do_reset(65535, 4);
      program_rule(0, 1'b0, 7, 0, RESP_FAULT);
      program_rule(1, 1'b0, 0, 0, RESP_DERROR);
      for (int k = 0; k < 7; k++) begin
         response_in = rand_resp(RESP_DONE, 1'b1);
         tick();
      end
      response_in = rand_resp(RESP_DONE, 1'b1);
      cfg_clear   = 1'b1;
      tick();
      cfg_clear   = 1'b0;
      n_cmp++;
      if (resp_out_a.response !== RESP_FAULT || ord_a !== 16'd0 || icnt_a !== 32'd0) begin
         n_fail++;
         $display("FAIL clear_same got code %h ord %0d cnt %0d want 07 0 0", resp_out_a.response, ord_a, icnt_a);
      end
      response_in = rand_resp(RESP_DONE, 1'b1);
      tick();
      n_cmp++;
      if (resp_out_a.response !== RESP_DERROR || ord_a !== 16'd1 || icnt_a !== 32'd1) begin
         n_fail++;
         $display("FAIL clear_next got code %h ord %0d cnt %0d want 03 1 1", resp_out_a.response, ord_a, icnt_a);
      end
   endtask

   task automatic test_cfg_collision();
      do_reset(65535, 4);
      for (int k = 0; k < 3; k++) begin
         response_in = rand_resp(RESP_DONE, 1'b1);
         tick();
      end
      response_in = rand_resp(RESP_DONE, 1'b1);
      cfg_valid = 1'b1; cfg_index = 2'd0; cfg_enable = 1'b1; cfg_mode = 1'b0;
      cfg_start = 16'd3; cfg_code = RESP_FAULT;
      tick();
      cfg_valid = 1'b0;
      n_cmp++;
      if (resp_out_a.response !== RESP_DONE) begin
         n_fail++;
         $display("FAIL collision_old got %h want %h", resp_out_a.response, RESP_DONE);
      end
      program_rule(0, 1'b0, 4, 0, RESP_FAULT);
      response_in = rand_resp(RESP_DONE, 1'b1);
      tick();
      n_cmp++;
      if (resp_out_a.response !== RESP_FAULT) begin
         n_fail++;
         $display("FAIL collision_new got %h want %h", resp_out_a.response, RESP_FAULT);
      end
   endtask

   task automatic test_saturation();
      logic [7:0] want;
      do_reset(15, 3);
      program_rule(3, 1'b1, 0, 15, RESP_FAULT);
      program_rule(0, 1'b1, 15, 15, RESP_AERROR);
      for (int k = 0; k < 20; k++) begin
         response_in = rand_resp(RESP_DONE, 1'b1);
         want = (k >= 15) ? RESP_AERROR : RESP_DONE;
         tick();
         n_cmp++;
         if (resp_out_b.response !== want || resp_out_b !== exp_out || ord_b !== 4'(m_ord)) begin
            n_fail++;
            $display("FAIL saturate k=%0d got %h ord %0d want code %h ord %0d", k, resp_out_b, ord_b, want, m_ord);
         end
      end
      n_cmp++;
      if (ord_b !== 4'd15 || icnt_b !== 32'd5) begin
         n_fail++;
         $display("FAIL saturate_final ord %0d cnt %0d want 15 5", ord_b, icnt_b);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset(65535, 4);
      program_rule(0, 1'b1, 0, 65535, RESP_FAULT);
      for (int k = 0; k < 6; k++) begin
         response_in = rand_resp(RESP_DONE, 1'b1);
         tick();
      end
      response_in = rand_resp(RESP_DONE, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++;
      if (resp_out_a.valid !== 1'b0 || icnt_a !== 32'd0) begin
         n_fail++;
         $display("FAIL midreset valid %b cnt %0d want 0 0", resp_out_a.valid, icnt_a);
      end
      for (int k = 0; k < 6; k++) begin
         response_in = rand_resp(RESP_DONE, 1'b1);
         tick();
         n_cmp++;
         if (resp_out_a.response !== RESP_DONE || resp_out_a !== exp_out) begin
            n_fail++;
            $display("FAIL midreset_after k=%0d got %h want code %h", k, resp_out_a, RESP_DONE);
         end
      end
   endtask

   task automatic test_random();
      int s;
      do_reset(65535, 4);
      for (int k = 0; k < 600; k++) begin
         response_in = rand_resp(pick_code(), 1'($urandom_range(0, 9) < 7));
         enabled_in  = ($urandom_range(0, 9) != 0);
         cfg_clear   = ($urandom_range(0, 49) == 0);
         cfg_valid   = ($urandom_range(0, 19) == 0);
         s           = $urandom_range(0, 60);
         cfg_index   = 2'($urandom);
         cfg_enable  = ($urandom_range(0, 4) != 0);
         cfg_mode    = 1'($urandom);
         cfg_start   = 16'(s);
         cfg_end     = 16'(s + $urandom_range(0, 25) - 5 < 0 ? 0 : s + $urandom_range(0, 25) - 5);
         cfg_code    = pick_code();
         tick();
         n_cmp++;
         if (resp_out_a !== exp_out || ord_a !== 16'(m_ord) || icnt_a !== 32'(m_cnt)) begin
            n_fail++;
            $display("FAIL random k=%0d got %h/%0d/%0d want %h/%0d/%0d", k, resp_out_a, ord_a, icnt_a, exp_out, m_ord, m_cnt);
         end
      end
      idle_inputs();
   endtask

`else

   task automatic test_passthrough();
      ResponseInterface prev;
      idle_inputs();
      for (int k = 0; k < 1000; k++) begin
         response_in = rand_resp(pick_code(), 1'($urandom));
         enabled_in  = 1'($urandom);
         cfg_valid   = 1'($urandom);
         cfg_index   = 2'($urandom);
         cfg_enable  = 1'b1;
         cfg_mode    = 1'($urandom);
         cfg_start   = 16'($urandom_range(0, 8));
         cfg_end     = 16'($urandom_range(0, 40));
         cfg_code    = pick_code();
         cfg_clear   = 1'($urandom);
         reset       = (k == 500);
         prev        = reset ? '0 : response_in;
         @(posedge clock);
         #1;
         n_cmp++;
         if (resp_out_a !== prev || resp_out_b !== prev || icnt_a !== 32'd0 || ord_a !== 16'd0) begin
            n_fail++;
            $display("FAIL passthrough k=%0d got %h cnt %0d ord %0d want %h", k, resp_out_a, icnt_a, ord_a, prev);
         end
      end
      reset = 1'b0;
      idle_inputs();
   endtask

`endif

   initial begin
      reset = 1'b0;
      idle_inputs();
      test_reset();
`ifdef RESPONSE_FAULT_INJECT_EN
      test_oneshot();
      test_window();
      test_overlap();
      test_clear();
      test_cfg_collision();
      test_saturation();
      test_reset_midstream();
      test_random();
`else
      test_passthrough();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
